alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width; legal values are powers of two >= 4.
REQ-002 The block SHALL have parameter SW, default $clog2(WIDTH) = 4, shift-amount width; it is derived and not overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in, input, WIDTH bits: operand.
REQ-006 The block SHALL have port ctrl, input, SW bits: shift amount, unsigned 0..WIDTH-1; bit k enables a stage shifting by 2^k.
REQ-007 The block SHALL have port op, input, 2 bits: operation select.
REQ-008 The block SHALL have port out, output, WIDTH bits: registered result.

Function
REQ-009 The block SHALL decode op as follows: 2'b00 logical shift left, 2'b01 logical shift right, 2'b10 rotate left, 2'b11 rotate right.
REQ-010 Logical shifts SHALL zero-fill vacated bit positions.
REQ-011 Logical-shift right SHALL NOT sign-extend.
REQ-012 Rotates SHALL wrap bits shifted out of one end into the other end.
REQ-013 The shift SHALL be a log-depth barrel of SW stages, where stage k applies a shift of 2^k when ctrl[k]=1 and passes data through otherwise, so any ctrl value 0..15 yields the combined amount.
REQ-014 When ctrl=0, out SHALL equal in for every op.
REQ-015 in, ctrl and op SHALL be sampled on each rising clk edge, and the result SHALL appear on out after that edge, giving 1-cycle latency.
REQ-016 out SHALL be held stable between edges.
REQ-017 The block SHALL have no handshake; a new operation is accepted every cycle, giving throughput of 1 per clock.
REQ-018 The datapath between input sampling and the out register SHALL be purely combinational.
REQ-019 out SHALL never be X when inputs are known.
REQ-020 The output SHALL depend only on the inputs sampled at the most recent non-reset edge, with no history.

Reset
REQ-021 When reset=1 at a rising clk edge, out SHALL become 16'h0000, overriding any operation presented that cycle.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result, and the first result after deassertion SHALL be the one for inputs sampled at the first edge with reset=0.
REQ-023 Reset SHALL have no asynchronous effect; out holds its value until the next rising edge.

Structure
REQ-024 A shared package alu_pkg SHALL hold the op encoding constants OP_SLL=2'b00, OP_SRL=2'b01, OP_ROL=2'b10 and OP_ROR=2'b11, plus the default WIDTH.
REQ-025 The block SHALL use one sub-module, shift_stage, parameterized by WIDTH and stage amount AMT, with inputs data, en and op and output data; alu SHALL instantiate SW of these in a chain and register the last stage's output.

Verification
REQ-026 The bench SHALL apply in=16'h75AB, op=00 with ctrl=1, 2, 4, 8 and require out = 16'hEB56, D6AC, 5AB0, AB00 respectively, one cycle later.
REQ-027 The bench SHALL apply in=16'h75AB, op=01 with ctrl=1, 2, 4, 8 and require out = 16'h3AD5, 1D6A, 075A, 0075.
REQ-028 The bench SHALL apply in=16'h75AB, op=10 with ctrl=1, 2, 4, 8 and require out = 16'hEB56, D6AD, 5AB7, AB75.
REQ-029 The bench SHALL apply in=16'h75AB, op=11 with ctrl=1, 2, 4, 8 and require out = 16'hBAD5, DD6A, B75A, AB75.
REQ-030 The bench SHALL apply combined amounts and edge cases and require the following: in=16'h8001 op=10 ctrl=15 -> out = 16'hC000; in=16'h8001 op=00 ctrl=15 -> out = 16'h8000; in=16'hFFFF op=01 ctrl=15 -> out = 16'h0001; any op with ctrl=0 -> out = in.
REQ-031 The bench SHALL issue back-to-back ops on consecutive cycles, then assert reset for one edge between them, and require results in order at 1-cycle latency, out=16'h0000 after the reset edge, and correct output resuming on the next op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shift/rotate ALU.
//   DEFAULT_WIDTH : default datapath width
//   OP_*          : operation select encodings driven on the op port
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] OP_SLL = 2'b00;  // logical shift left
    localparam logic [1:0] OP_SRL = 2'b01;  // logical shift right
    localparam logic [1:0] OP_ROL = 2'b10;  // rotate left
    localparam logic [1:0] OP_ROR = 2'b11;  // rotate right

endpackage

// File: rtl/alu_shift_stage.sv
// One stage of the barrel shifter: shifts or rotates by a fixed AMT when enabled,
// otherwise passes data straight through. Purely combinational.
// Ports:
//   data_i : operand from the previous stage
//   en_i   : apply this stage's shift
//   op_i   : operation select (alu_pkg OP_* encodings)
//   data_o : result passed to the next stage
module shift_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned AMT   = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shifted;

    // AMT is always a power of two below WIDTH, so every slice below is non-empty.
    always_comb begin
        shifted = data_i;
        case (op_i)
            OP_SLL:  shifted = {data_i[WIDTH-1-AMT:0], {AMT{1'b0}}};
            OP_SRL:  shifted = {{AMT{1'b0}}, data_i[WIDTH-1:AMT]};
            OP_ROL:  shifted = {data_i[WIDTH-1-AMT:0], data_i[WIDTH-1:WIDTH-AMT]};
            OP_ROR:  shifted = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
            default: shifted = data_i;
        endcase
    end

    always_comb begin
        data_o = en_i ? shifted : data_i;
    end

endmodule

// File: rtl/alu.sv
// Registered barrel shift/rotate unit with one-cycle latency and one result per clock.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset, clears out
//   in    : operand
//   ctrl  : shift amount; bit k enables the stage that shifts by 2^k
//   op    : operation select (alu_pkg OP_* encodings)
//   out   : registered result
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [SW-1:0]    ctrl,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out
);

    // Reject widths the log-depth barrel cannot cover exactly.
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("alu: WIDTH must be a power of two >= 4");
    end

    // stage_data[k] feeds stage k; stage_data[SW] is the fully shifted value.
    logic [WIDTH-1:0] stage_data [SW+1];
    logic [WIDTH-1:0] out_q;

    assign stage_data[0] = in;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (2 ** k)
        ) u_stage (
            .data_i (stage_data[k]),
            .en_i   (ctrl[k]),
            .op_i   (op),
            .data_o (stage_data[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= stage_data[SW];
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [3:0]  ctrl;
    logic [1:0]  op;
    logic [15:0] dout;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] prev_exp;

    always #5 clk = ~clk;

    alu dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .ctrl  (ctrl),
        .op    (op),
        .out   (dout)
    );

    // Reference: move each source bit to its destination index; drop or wrap as the op requires.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] o,
                                          input int amt);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (o)
                2'b00: if (i + amt < 16) r[i + amt] = d[i];
                2'b01: if (i - amt >= 0) r[i - amt] = d[i];
                2'b10: r[(i + amt) % 16] = d[i];
                default: r[(i - amt + 16) % 16] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operation, confirm out still holds the previous result before the edge,
    // then check the new result just after the edge.
    task automatic step(input string tag, input logic [15:0] d, input logic [1:0] o,
                        input logic [3:0] c, input logic r, input logic [15:0] exp);
        din   = d;
        op    = o;
        ctrl  = c;
        reset = r;
        #2;
        check({tag, "_hold"}, dout, prev_exp);
        @(posedge clk);
        #1;
        check(tag, dout, exp);
        prev_exp = exp;
    endtask

    logic [15:0] sll_exp [4];
    logic [15:0] srl_exp [4];
    logic [15:0] rol_exp [4];
    logic [15:0] ror_exp [4];

    initial begin
        sll_exp = '{16'hEB56, 16'hD6AC, 16'h5AB0, 16'hAB00};
        srl_exp = '{16'h3AD5, 16'h1D6A, 16'h075A, 16'h0075};
        rol_exp = '{16'hEB56, 16'hD6AD, 16'h5AB7, 16'hAB75};
        ror_exp = '{16'hBAD5, 16'hDD6A, 16'hB75A, 16'hAB75};

        // Reset state
        din = 16'h1234; op = 2'b00; ctrl = 4'd3; reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", dout, 16'h0000);
        prev_exp = 16'h0000;

        // Single-stage directed vectors for each op, checked against both table and model
        for (int k = 0; k < 4; k++) begin
            logic [3:0] c;
            c = 4'(1 << k);
            step("sll_dir", 16'h75AB, 2'b00, c, 1'b0, sll_exp[k]);
            check("sll_model", model(16'h75AB, 2'b00, int'(c)), sll_exp[k]);
            step("srl_dir", 16'h75AB, 2'b01, c, 1'b0, srl_exp[k]);
            step("rol_dir", 16'h75AB, 2'b10, c, 1'b0, rol_exp[k]);
            step("ror_dir", 16'h75AB, 2'b11, c, 1'b0, ror_exp[k]);
        end

        // Combined amounts and edges
        step("rol_15", 16'h8001, 2'b10, 4'd15, 1'b0, 16'hC000);
        step("sll_15", 16'h8001, 2'b00, 4'd15, 1'b0, 16'h8000);
        step("srl_15_nosext", 16'hFFFF, 2'b01, 4'd15, 1'b0, 16'h0001);
        step("ror_15", 16'h8001, 2'b11, 4'd15, 1'b0, 16'h0003);
        for (int o = 0; o < 4; o++) begin
            step("ctrl0_pass", 16'hC3A5, 2'(o), 4'd0, 1'b0, 16'hC3A5);
        end

        // Back-to-back ops with a one-edge reset in the middle
        step("b2b_0", 16'h1357, 2'b00, 4'd4, 1'b0, 16'h3570);
        step("b2b_1", 16'h1357, 2'b11, 4'd4, 1'b0, 16'h7135);
        step("b2b_rst", 16'hFFFF, 2'b10, 4'd1, 1'b1, 16'h0000);
        step("b2b_2", 16'h8000, 2'b01, 4'd15, 1'b0, 16'h0001);
        step("b2b_3", 16'h00F0, 2'b10, 4'd12, 1'b0, 16'h000F);

        // Randomized stream against the reference, with occasional resets
        for (int n = 0; n < 300; n++) begin
            logic [15:0] d;
            logic [1:0]  o;
            logic [3:0]  c;
            logic        r;
            d = 16'($urandom);
            o = 2'($urandom_range(3, 0));
            c = 4'($urandom_range(15, 0));
            r = ($urandom_range(15, 0) == 0);
            step("random", d, o, c, r, r ? 16'h0000 : model(d, o, int'(c)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
